input_conditioner: RTL and testbench

- Front-end conditioning stage for the memory-mapped peripheral register block; sits directly upstream of its switch and pushbutton input words.
- Synchronises the asynchronous board switch and pushbutton pins into clk, debounces each bit independently, and latches sticky press flags for pushbuttons.
- Presents both results as WIDTH-bit zero-extended words, which the peripheral block samples every cycle.
- Also produces a one-cycle press-event pulse per pushbutton.

---
 rtl/input_conditioner.sv | 106 ++++++++++
 tb/tb_input_conditioner.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// Switch/pushbutton front end: two-flop synchroniser, per-bit debounce,
// press-event pulses and sticky press flags, presented as zero-extended words.
module input_conditioner #(
  parameter int WIDTH           = 64,
  parameter int N_SW            = 4,
  parameter int N_PB            = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SW-1:0]  sw_raw,
  input  logic [N_PB-1:0]  pb_raw,
  input  logic             clr_en,
  input  logic [N_PB-1:0]  clr_mask,
  output logic [WIDTH-1:0] swOut,
  output logic [WIDTH-1:0] pshOut,
  output logic [N_PB-1:0]  psh_evt
);

  localparam int NB = N_SW + N_PB;
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  // Switches occupy the low bits, pushbuttons the high bits of one vector.
  logic [NB-1:0] raw;
  logic [NB-1:0] s1_q, s2_q;
  logic [NB-1:0] stb_lvl;
  logic [NB-1:0] flip;

  assign raw = {pb_raw, sw_raw};

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_deb
      logic [CW-1:0] cnt_q, cnt_d;
      logic          stb_q, stb_d;
      logic          differ;

      assign differ      = s2_q[gi] != stb_q;
      assign flip[gi]    = differ && (cnt_q == CNT_MAX);
      assign stb_lvl[gi] = stb_q;

      // Any cycle of agreement restarts the count from zero.
      always_comb begin
        cnt_d = '0;
        stb_d = stb_q;
        if (differ) begin
          if (cnt_q == CNT_MAX) stb_d = s2_q[gi];
          else                  cnt_d = cnt_q + CW'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_q <= '0;
          stb_q <= 1'b0;
        end else begin
          cnt_q <= cnt_d;
          stb_q <= stb_d;
        end
      end
    end
  endgenerate

  logic [N_PB-1:0] rise;
  logic [N_PB-1:0] evt_q;
  logic [N_PB-1:0] sticky_q, sticky_d;

  // A flip towards 1 is exactly a debounced 0->1 transition.
  assign rise = flip[NB-1:N_SW] & s2_q[NB-1:N_SW];

  always_comb begin
    sticky_d = (sticky_q & ~(clr_mask & {N_PB{clr_en}})) | rise;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      evt_q    <= '0;
      sticky_q <= '0;
    end else begin
      evt_q    <= rise;
      sticky_q <= sticky_d;
    end
  end

  assign psh_evt = evt_q;

  always_comb begin
    swOut                  = '0;
    swOut[N_SW-1:0]        = stb_lvl[N_SW-1:0];
    pshOut                 = '0;
    pshOut[N_PB-1:0]       = stb_lvl[NB-1:N_SW];
    pshOut[2*N_PB-1:N_PB]  = sticky_q;
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: directed scenarios plus random pin activity,
// all compared against a window-based behavioural model every cycle.
module tb_input_conditioner;

  localparam int D = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  sw_raw, pb_raw, clr_mask;
  logic        clr_en;
  logic [63:0] swOut, pshOut;
  logic [3:0]  psh_evt;

  int total = 0;
  int bad   = 0;

  input_conditioner #(
    .WIDTH(64), .N_SW(4), .N_PB(4), .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk(clk), .rst(rst), .sw_raw(sw_raw), .pb_raw(pb_raw),
    .clr_en(clr_en), .clr_mask(clr_mask),
    .swOut(swOut), .pshOut(pshOut), .psh_evt(psh_evt)
  );

  always #5 clk = ~clk;

  // Model: raw pins reach the debouncer two edges later; a level is accepted
  // once the last D samples since reset all disagree with the current level.
  logic [7:0] rawq[$];
  logic [7:0] win[$];
  logic [7:0] m_stb;
  logic [3:0] m_evt, m_sticky;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic [3:0] s, input logic [3:0] p,
                            input logic ce, input logic [3:0] cm);
    logic [7:0] s2, nstb;
    logic [3:0] rs;
    bit all_diff;
    if (r) begin
      rawq = {8'h00, 8'h00};
      win.delete();
      m_stb = '0; m_evt = '0; m_sticky = '0;
    end else begin
      s2 = rawq.pop_front();
      rawq.push_back({p, s});
      win.push_back(s2);
      if (win.size() > D) void'(win.pop_front());
      nstb = m_stb;
      for (int b = 0; b < 8; b++) begin
        if (win.size() == D) begin
          all_diff = 1;
          foreach (win[j]) if (win[j][b] == m_stb[b]) all_diff = 0;
          if (all_diff) nstb[b] = ~m_stb[b];
        end
      end
      rs       = nstb[7:4] & ~m_stb[7:4];
      m_evt    = rs;
      m_sticky = (m_sticky & ~(ce ? cm : 4'h0)) | rs;
      m_stb    = nstb;
    end
  endtask

  task automatic step(input logic r, input logic [3:0] s, input logic [3:0] p,
                      input logic ce, input logic [3:0] cm);
    rst = r; sw_raw = s; pb_raw = p; clr_en = ce; clr_mask = cm;
    @(posedge clk);
    model_step(r, s, p, ce, cm);
    #1;
    check("swOut",   swOut,   {60'b0, m_stb[3:0]});
    check("pshOut",  pshOut,  {56'b0, m_sticky, m_stb[7:4]});
    check("psh_evt", {60'b0, psh_evt}, {60'b0, m_evt});
  endtask

  logic [63:0] acc;
  logic [7:0]  cur;
  logic        r_rnd, ce_rnd;
  logic [3:0]  cm_rnd;

  initial begin
    rst = 1'b1; sw_raw = '0; pb_raw = '0; clr_en = 1'b0; clr_mask = '0;
    rawq = {8'h00, 8'h00};
    m_stb = '0; m_evt = '0; m_sticky = '0;

    // 1: reset with switches high, then exact latency after release
    for (int k = 0; k < 3; k++) begin
      step(1, 4'hF, 4'h0, 0, 4'h0);
      check("t1_rst_sw", swOut, 64'h0);
    end
    for (int k = 1; k <= 12; k++) begin
      step(0, 4'hF, 4'h0, 0, 4'h0);
      if (k == 9)  check("t1_sw_e9",  swOut, 64'h0);
      if (k == 10) check("t1_sw_e10", swOut, 64'hF);
    end

    // 2: single clean switch rise
    for (int k = 0; k < 12; k++) step(0, 4'h0, 4'h0, 0, 4'h0);
    for (int k = 1; k <= 11; k++) begin
      step(0, 4'h4, 4'h0, 0, 4'h0);
      if (k == 9)  check("t2_sw_e9",  swOut, 64'h0);
      if (k == 10) check("t2_sw_e10", swOut, 64'h4);
    end

    // 3: short pushbutton pulse is filtered
    acc = '0;
    for (int k = 0; k < 20; k++) begin
      step(0, 4'h4, (k < 5) ? 4'h2 : 4'h0, 0, 4'h0);
      acc = acc | pshOut | {60'b0, psh_evt};
    end
    check("t3_glitch", acc, 64'h0);

    // 4: long press, event and sticky flag
    for (int k = 1; k <= 20; k++) begin
      step(0, 4'h4, 4'h1, 0, 4'h0);
      if (k == 10) begin
        check("t4_psh_e10", pshOut, 64'h11);
        check("t4_evt_e10", {60'b0, psh_evt}, 64'h1);
      end
      if (k == 11) check("t4_evt_e11", {60'b0, psh_evt}, 64'h0);
    end
    for (int k = 0; k < 12; k++) step(0, 4'h4, 4'h0, 0, 4'h0);
    check("t4_release", pshOut, 64'h10);

    // 5: clearing, empty mask, and set-wins-over-clear
    step(0, 4'h4, 4'h0, 1, 4'h0);
    check("t5_mask0", pshOut, 64'h10);
    step(0, 4'h4, 4'h0, 1, 4'h1);
    check("t5_clear", pshOut, 64'h0);
    for (int k = 1; k <= 10; k++) step(0, 4'h4, 4'h1, (k == 10), 4'h1);
    check("t5_setwins", pshOut, 64'h11);
    for (int k = 0; k < 12; k++) step(0, 4'h4, 4'h0, 0, 4'h0);

    // 6: reset mid-debounce discards the partial count
    for (int k = 0; k < 5; k++) step(0, 4'h4, 4'h8, 0, 4'h0);
    step(1, 4'h4, 4'h8, 0, 4'h0);
    check("t6_rst", pshOut, 64'h0);
    for (int k = 1; k <= 12; k++) begin
      step(0, 4'h4, 4'h8, 0, 4'h0);
      if (k == 9)  check("t6_evt_e9",  {60'b0, psh_evt}, 64'h0);
      if (k == 10) check("t6_evt_e10", {60'b0, psh_evt}, 64'h8);
    end

    // Random pin activity with mixed hold lengths, clears and rare resets
    cur = {4'h8, 4'h4};
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 8; b++)
        if ($urandom_range(0, 11) == 0) cur[b] = ~cur[b];
      r_rnd  = ($urandom_range(0, 499) == 0);
      ce_rnd = ($urandom_range(0, 7) == 0);
      cm_rnd = 4'($urandom_range(0, 15));
      step(r_rnd, cur[3:0], cur[7:4], ce_rnd, cm_rnd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
